// File: rtl/dclk_tx_lanes_if.sv
// Router-side push port and serial channel side of the lane transmitter.
// master = router/channel environment, slave = transmitter.
interface dclk_tx_lanes_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 1
);
    logic              req;
    logic [DATA_W-1:0] parallel_in;
    logic              tx_busy;
    logic              drop;
    logic              channel_busy;
    logic [LANES-1:0]  serial_out;
    logic              tx_active;
    logic [15:0]       frames_sent;

    modport master (
        output req, parallel_in, channel_busy,
        input  tx_busy, drop, serial_out, tx_active, frames_sent
    );

    modport slave (
        input  req, parallel_in, channel_busy,
        output tx_busy, drop, serial_out, tx_active, frames_sent
    );
endinterface

// File: rtl/dclk_tx_lanes.sv
// Buffers router words and sends each as a framed burst (start, data, parity, gap) over LANES wires.
// Push to START visible after 2 edges; push refused while full; channel_busy checked only between frames.
module dclk_tx_lanes #(
    parameter int DATA_W    = 16,
    parameter int LANES     = 1,
    parameter int DEPTH     = 2,
    parameter int PARITY_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    dclk_tx_lanes_if.slave     bus
);
    localparam int BEATS = DATA_W / LANES;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GAP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop_q;

    state_t            state_q, state_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [LANES-1:0]  ser_q, ser_d;
    logic              act_q, act_d;
    logic [15:0]       sent_q;
    logic              sent_inc;

    // A full FIFO refuses the push even if the head leaves on the same edge.
    assign full = (count == FULL_CNT);
    assign push = bus.req && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.parallel_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            drop_q <= bus.req && full;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ser_q   <= '0;
            act_q   <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            act_q   <= act_d;
            sent_q  <= sent_q + 16'(sent_inc);
        end
    end

    // Outputs are computed for the state being entered, so state_q always names
    // the beat currently on the wire. The gap beat doubles as the idle decision
    // point, which keeps back-to-back frames at 1+BEATS+PARITY_EN+1 clocks.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        shift_d  = shift_q;
        par_d    = par_q;
        ser_d    = '0;
        act_d    = 1'b0;
        pop      = 1'b0;
        sent_inc = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                if (count != '0 && !bus.channel_busy) begin
                    pop     = 1'b1;
                    state_d = START;
                    shift_d = mem[rd_ptr];
                    par_d   = ^mem[rd_ptr];
                    ser_d   = '1;
                    act_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                beat_d  = '0;
                ser_d   = shift_q[LANES-1:0];
                shift_d = shift_q >> LANES;
                act_d   = 1'b1;
            end
            DATA: begin
                if (beat_q == LAST_BEAT) begin
                    if (PARITY_EN != 0) begin
                        state_d  = PARITY;
                        ser_d[0] = par_q;
                        act_d    = 1'b1;
                    end else begin
                        state_d  = GAP;
                        sent_inc = 1'b1;
                    end
                end else begin
                    beat_d  = beat_q + 1'b1;
                    ser_d   = shift_q[LANES-1:0];
                    shift_d = shift_q >> LANES;
                    act_d   = 1'b1;
                end
            end
            PARITY: begin
                state_d  = GAP;
                sent_inc = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_busy     = full;
    assign bus.drop        = drop_q;
    assign bus.serial_out  = ser_q;
    assign bus.tx_active   = act_q;
    assign bus.frames_sent = sent_q;
endmodule
